// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader and its timeout helper.
package uart_loader_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned LOW_BYTES_W    = 24;
   localparam int unsigned WORD_CNT_W     = 9;
   localparam logic [BYTE_W-1:0] HDR_BYTE_DEFAULT = 8'h4C;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DATA,
      ST_CSUM,
      ST_DONE
   } loader_state_e;

endpackage

// File: rtl/uart_rx_timeout.sv
// Loadable down-counter: reloads on each strobe or while disabled, pulses expire_c
// when CYCLES clock cycles pass without a strobe while enabled.
module uart_rx_timeout #(
   parameter int unsigned CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_c
);

   localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= RELOAD;
      end else if (clr_i || !en_i) begin
         cnt_q <= RELOAD;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign expire_c = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/uart_program_loader.sv
// Decodes UART load packets (HDR, N, 4*N little-endian data bytes) into imem word writes,
// holding the CPU for the duration. Optional checksum byte: UART_LOADER_CHECKSUM_EN.
module uart_program_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned         ADDR_W         = 8,
   parameter logic [ADDR_W-1:0]   BASE_ADDR      = '0,
   parameter logic [BYTE_W-1:0]   HDR_BYTE       = HDR_BYTE_DEFAULT,
   parameter int unsigned         TIMEOUT_CYCLES = 100000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BYTE_W-1:0]   rx_data,
   input  logic                rx_data_rdy,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [WORD_W-1:0]   imem_wdata,
   output logic                cpu_hold,
   output logic                busy,
   output logic                load_done,
   output logic                load_err
);

   loader_state_e            state_q, state_d;
   logic [1:0]               byte_idx_q, byte_idx_d;
   logic [WORD_CNT_W-1:0]    word_cnt_q, word_cnt_d;
   logic [LOW_BYTES_W-1:0]   word_q, word_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [WORD_W-1:0]        wdata_q, wdata_d;
   logic                     we_q, we_d;
   logic                     hold_q, hold_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]        csum_q, csum_d;
`endif
   logic                     timer_en;
   logic                     expire;

   assign timer_en = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CSUM);

   uart_rx_timeout #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .en_i     (timer_en),
      .clr_i    (rx_data_rdy),
      .expire_c (expire)
   );

   // Next-state and output decode
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      word_cnt_d = word_cnt_q;
      word_d     = word_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      hold_d     = hold_q;
      done_d     = 1'b0;
      err_d      = err_q;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      // Address advances the cycle after each write strobe
      if (we_q) addr_d = addr_q + ADDR_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (rx_data_rdy && (rx_data == HDR_BYTE)) begin
               state_d = ST_COUNT;
               hold_d  = 1'b1;
               err_d   = 1'b0;
            end
         end
         ST_COUNT: begin
            if (rx_data_rdy) begin
               word_cnt_d = (rx_data == '0) ? WORD_CNT_W'(256) : WORD_CNT_W'(rx_data);
               addr_d     = BASE_ADDR;
               byte_idx_d = 2'd0;
`ifdef UART_LOADER_CHECKSUM_EN
               csum_d     = '0;
`endif
               state_d    = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_data_rdy) begin
`ifdef UART_LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ rx_data;
`endif
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: word_d[7:0]   = rx_data;
                  2'd1: word_d[15:8]  = rx_data;
                  2'd2: word_d[23:16] = rx_data;
                  default: begin
                     we_d       = 1'b1;
                     wdata_d    = {rx_data, word_q};
                     word_cnt_d = word_cnt_q - WORD_CNT_W'(1);
                     if (word_cnt_q == WORD_CNT_W'(1)) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                     end
                  end
               endcase
            end
         end
`ifdef UART_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (rx_data_rdy) begin
               if (rx_data == csum_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Inter-byte silence abandons the packet; partial word is dropped
      if (expire) begin
         state_d    = ST_IDLE;
         err_d      = 1'b1;
         byte_idx_d = 2'd0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         byte_idx_q <= '0;
         word_cnt_q <= '0;
         word_q     <= '0;
         addr_q     <= BASE_ADDR;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         hold_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         word_cnt_q <= word_cnt_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         hold_q     <= hold_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef UART_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign busy       = busy_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed self-checking bench for uart_program_loader (ADDR_W=8, BASE_ADDR=0xFE, short timeout).
module tb_uart_program_loader;

   localparam int unsigned ADDR_W  = 8;
   localparam logic [7:0]  BASE    = 8'hFE;
   localparam int unsigned TMO     = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_data_rdy;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold, busy, load_done, load_err;

   int          n_checks = 0;
   int          n_errors = 0;
   int          wr_n = 0;
   int          done_n = 0;
   logic [7:0]  wa [0:1023];
   logic [31:0] wd [0:1023];
   logic [7:0]  csum;

   always #5 clk = ~clk;

   uart_program_loader #(
      .ADDR_W         (ADDR_W),
      .BASE_ADDR      (BASE),
      .HDR_BYTE       (8'h4C),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_data_rdy (rx_data_rdy),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .cpu_hold    (cpu_hold),
      .busy        (busy),
      .load_done   (load_done),
      .load_err    (load_err)
   );

   // Write/done log sampled away from the active edge
   always @(negedge clk) begin
      if (imem_we === 1'b1 && wr_n < 1024) begin
         wa[wr_n] = imem_addr;
         wd[wr_n] = imem_wdata;
         wr_n = wr_n + 1;
      end
      if (load_done === 1'b1) done_n = done_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; strobe is sampled at the following posedge
   task automatic send_byte(input logic [7:0] b);
      rx_data     = b;
      rx_data_rdy = 1'b1;
      @(negedge clk);
      rx_data_rdy = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] b);
      csum = csum ^ b;
      send_byte(b);
   endtask

   task automatic send_word(input logic [31:0] w);
      send_data(w[7:0]);
      send_data(w[15:8]);
      send_data(w[23:16]);
      send_data(w[31:24]);
   endtask

   task automatic send_csum(input logic [7:0] xor_mask);
`ifdef UART_LOADER_CHECKSUM_EN
      send_byte(csum ^ xor_mask);
`else
      if (xor_mask != 8'h00) csum = csum ^ xor_mask;
`endif
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] big_word(input int i);
      logic [7:0] iv;
      iv = 8'(i);
      return {iv, 8'h4C, iv ^ 8'h5A, 8'h4C};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int d0;
      rst = 1'b1;
      rx_data = 8'h00;
      rx_data_rdy = 1'b0;
      csum = 8'h00;
      idle(2);
      check("rst_we",    32'(imem_we),    32'd0);
      check("rst_addr",  32'(imem_addr),  32'(BASE));
      check("rst_wdata", imem_wdata,      32'd0);
      check("rst_hold",  32'(cpu_hold),   32'd0);
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_done",  32'(load_done),  32'd0);
      check("rst_err",   32'(load_err),   32'd0);
      rst = 1'b0;
      idle(2);

      // Basic two-word load, spaced bytes
      w0 = wr_n; d0 = done_n;
      send_byte(8'h4C);
      check("t1_hold_hdr", 32'(cpu_hold), 32'd1);
      check("t1_busy_hdr", 32'(busy),     32'd1);
      send_byte(8'h02);
      csum = 8'h00;
      send_word(32'h1234_5678); idle(1);
      send_word(32'hDEAD_BEEF); idle(1);
      send_csum(8'h00);
      idle(4);
      check("t1_nwr",   32'(wr_n - w0),   32'd2);
      check("t1_addr0", 32'(wa[w0]),      32'(BASE));
      check("t1_data0", wd[w0],           32'h1234_5678);
      check("t1_addr1", 32'(wa[w0+1]),    32'(8'(BASE + 8'd1)));
      check("t1_data1", wd[w0+1],         32'hDEAD_BEEF);
      check("t1_done",  32'(done_n - d0), 32'd1);
      check("t1_hold",  32'(cpu_hold),    32'd0);
      check("t1_busy",  32'(busy),        32'd0);
      check("t1_err",   32'(load_err),    32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
      // Bad checksum: words still land, error sticks, CPU stays held
      w0 = wr_n; d0 = done_n;
      send_byte(8'h4C); send_byte(8'h02);
      csum = 8'h00;
      send_word(32'h1234_5678);
      send_word(32'hDEAD_BEEF);
      send_csum(8'hFF ^ csum);
      idle(4);
      check("t2_nwr",  32'(wr_n - w0),   32'd2);
      check("t2_data1", wd[w0+1],        32'hDEAD_BEEF);
      check("t2_err",  32'(load_err),    32'd1);
      check("t2_hold", 32'(cpu_hold),    32'd1);
      check("t2_done", 32'(done_n - d0), 32'd0);
      send_byte(8'h4C);
      check("t2_err_clr", 32'(load_err), 32'd0);
      send_byte(8'h01);
      csum = 8'h00;
      send_word(32'hCAFE_F00D);
      send_csum(8'h00);
      idle(3);
      check("t2_good_done", 32'(done_n - d0), 32'd1);
      check("t2_good_hold", 32'(cpu_hold),    32'd0);
`endif

      // Timeout after a partial word; boundary one cycle before expiry
      w0 = wr_n;
      send_byte(8'h4C); send_byte(8'h01);
      send_byte(8'hAA); send_byte(8'hBB);
      idle(TMO - 1);
      check("t3_err_early",  32'(load_err), 32'd0);
      check("t3_busy_early", 32'(busy),     32'd1);
      idle(1);
      check("t3_err",  32'(load_err),  32'd1);
      check("t3_busy", 32'(busy),      32'd0);
      check("t3_hold", 32'(cpu_hold),  32'd1);
      check("t3_nwr",  32'(wr_n - w0), 32'd0);

      // N=0 -> 256 words, back-to-back strobes, 0x4C inside data
      w0 = wr_n; d0 = done_n;
      send_byte(8'h4C);
      check("t4_err_clr", 32'(load_err), 32'd0);
      send_byte(8'h00);
      csum = 8'h00;
      for (int i = 0; i < 256; i++) send_word(big_word(i));
      send_csum(8'h00);
      idle(4);
      check("t4_nwr", 32'(wr_n - w0), 32'd256);
      for (int i = 0; i < 256; i++) begin
         if (w0 + i < 1024) begin
            check($sformatf("t4_addr%0d", i), 32'(wa[w0+i]), 32'(8'(BASE + 8'(i))));
            check($sformatf("t4_data%0d", i), wd[w0+i], big_word(i));
         end
      end
      check("t4_done", 32'(done_n - d0), 32'd1);
      check("t4_hold", 32'(cpu_hold),    32'd0);

      // Short back-to-back packet made mostly of header-valued bytes
      w0 = wr_n; d0 = done_n;
      send_byte(8'h4C); send_byte(8'h02);
      csum = 8'h00;
      send_word(32'h4C4C_4C4C);
      send_word(32'h4C12_4C34);
      send_csum(8'h00);
      idle(4);
      check("t5_nwr",   32'(wr_n - w0),   32'd2);
      check("t5_data0", wd[w0],           32'h4C4C_4C4C);
      check("t5_data1", wd[w0+1],         32'h4C12_4C34);
      check("t5_addr1", 32'(wa[w0+1]),    32'(8'(BASE + 8'd1)));
      check("t5_done",  32'(done_n - d0), 32'd1);

      // Async reset in the middle of the second word
      w0 = wr_n;
      send_byte(8'h4C); send_byte(8'h03);
      send_word(32'h0102_0304);
      send_byte(8'h05); send_byte(8'h06);
      #2 rst = 1'b1;
      #1;
      check("t6_we",    32'(imem_we),   32'd0);
      check("t6_addr",  32'(imem_addr), 32'(BASE));
      check("t6_hold",  32'(cpu_hold),  32'd0);
      check("t6_busy",  32'(busy),      32'd0);
      check("t6_wdata", imem_wdata,     32'd0);
      @(negedge clk);
      rst = 1'b0;
      send_byte(8'h07); send_byte(8'h08); send_byte(8'h4D); send_byte(8'h00);
      idle(5);
      check("t6_nwr",   32'(wr_n - w0), 32'd1);
      check("t6_data0", wd[w0],         32'h0102_0304);
      check("t6_idle",  32'(busy),      32'd0);
      check("t6_hold2", 32'(cpu_hold),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
